vga_stream_sink: RTL

- Avalon-ST video sink: the receiving end of the pixel stream emitted by the GPU VGA streaming master.
- Accepts 30-bit RGB beats framed by startofpacket/endofpacket and converts each to COLOR_WIDTH (RGB565).
- Writes each pixel into the per-core framebuffer bank that owns its screen band.
- Used for frame capture and loopback checking of the VGA path. Single clock domain.

---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_stream_sink_if.sv | 34 +++
 rtl/vga_pixel_addr_gen.sv | 78 +++++++
 rtl/vga_stream_sink.sv | 129 ++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared state type, RGB bit positions and colour conversion for the VGA stream sink.
package vga_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } vga_state_e;

    localparam int R_HI = 29;
    localparam int R_LO = 22;
    localparam int G_HI = 19;
    localparam int G_LO = 12;
    localparam int B_HI = 9;
    localparam int B_LO = 2;

    // Keep the most significant bits of each channel; no rounding.
    function automatic logic [15:0] rgb30_to_565(input logic [29:0] pix);
        return {pix[R_HI -: 5], pix[G_HI -: 6], pix[B_HI -: 5]};
    endfunction

    // Counter/index width that stays at least one bit for degenerate sizes.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_stream_sink_if.sv
// Avalon-ST pixel input plus framebuffer write bus of the VGA stream sink.
interface vga_stream_sink_if
    import vga_pkg::*;
#(
    parameter int CORES_COUNT   = 10,
    parameter int BUFFER_ADDR_W = 32,
    parameter int COLOR_WIDTH   = 16
);
    localparam int SEL_W = idx_width(CORES_COUNT);

    logic [29:0]              s_data;
    logic                     s_startofpacket;
    logic                     s_endofpacket;
    logic                     s_valid;
    logic                     s_ready;
    logic                     write;
    logic [SEL_W-1:0]         wselect;
    logic [BUFFER_ADDR_W-1:0] waddress;
    logic [COLOR_WIDTH-1:0]   wdata;
    logic                     wbusy;
    logic                     frame_done;
    logic                     sync_err;

    modport master (
        output s_data, s_startofpacket, s_endofpacket, s_valid, wbusy,
        input  s_ready, write, wselect, waddress, wdata, frame_done, sync_err
    );

    modport slave (
        input  s_data, s_startofpacket, s_endofpacket, s_valid, wbusy,
        output s_ready, write, wselect, waddress, wdata, frame_done, sync_err
    );

endinterface

// File: rtl/vga_pixel_addr_gen.sv
// Pixel position tracker: column x, line-in-band ppuy and bank ppui, with bank address.
module vga_pixel_addr_gen
    import vga_pkg::*;
#(
    parameter int VGA_WIDTH     = 800,
    parameter int VGA_HEIGHT    = 600,
    parameter int CORES_COUNT   = 10,
    parameter int BUFFER_ADDR_W = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              restart,
    input  logic                              advance,
    output logic [idx_width(CORES_COUNT)-1:0] sel,
    output logic [BUFFER_ADDR_W-1:0]          addr,
    output logic                              band_wrap
);
    localparam int LINES = VGA_HEIGHT / CORES_COUNT;
    localparam int XW    = idx_width(VGA_WIDTH);
    localparam int YW    = idx_width(LINES);
    localparam int IW    = idx_width(CORES_COUNT);
    localparam logic [XW-1:0] X_LAST = XW'(VGA_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(LINES - 1);
    localparam logic [IW-1:0] I_LAST = IW'(CORES_COUNT - 1);

    logic [XW-1:0] x_r, x_b_s, x_n_s;
    logic [YW-1:0] ppuy_r, ppuy_b_s, ppuy_n_s;
    logic [IW-1:0] ppui_r, ppui_b_s, ppui_n_s;

    // restart makes the current beat pixel (0,0) in the same cycle
    assign x_b_s    = restart ? {XW{1'b0}} : x_r;
    assign ppuy_b_s = restart ? {YW{1'b0}} : ppuy_r;
    assign ppui_b_s = restart ? {IW{1'b0}} : ppui_r;

    assign sel       = ppui_b_s;
    assign addr      = BUFFER_ADDR_W'(ppuy_b_s) * BUFFER_ADDR_W'(VGA_WIDTH) + BUFFER_ADDR_W'(x_b_s);
    assign band_wrap = (x_b_s == X_LAST) && (ppuy_b_s == Y_LAST);

    // Raster-order increment: x, then line within band, then bank.
    always_comb begin
        x_n_s    = x_b_s;
        ppuy_n_s = ppuy_b_s;
        ppui_n_s = ppui_b_s;
        if (advance) begin
            if (x_b_s == X_LAST) begin
                x_n_s = {XW{1'b0}};
                if (ppuy_b_s == Y_LAST) begin
                    ppuy_n_s = {YW{1'b0}};
                    if (ppui_b_s == I_LAST) begin
                        ppui_n_s = {IW{1'b0}};
                    end else begin
                        ppui_n_s = ppui_b_s + IW'(1);
                    end
                end else begin
                    ppuy_n_s = ppuy_b_s + YW'(1);
                end
            end else begin
                x_n_s = x_b_s + XW'(1);
            end
        end else begin
            x_n_s = x_b_s;
        end
    end

    // Position registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r    <= {XW{1'b0}};
            ppuy_r <= {YW{1'b0}};
            ppui_r <= {IW{1'b0}};
        end else begin
            x_r    <= x_n_s;
            ppuy_r <= ppuy_n_s;
            ppui_r <= ppui_n_s;
        end
    end

endmodule

// File: rtl/vga_stream_sink.sv
// Avalon-ST video sink writing RGB565 pixels into per-core framebuffer banks.
// Optional VGA_SINK_ERR_COUNT_EN adds a saturating err_count output.
module vga_stream_sink
    import vga_pkg::*;
#(
    parameter int VGA_WIDTH     = 800,
    parameter int VGA_HEIGHT    = 600,
    parameter int CORES_COUNT   = 10,
    parameter int BUFFER_ADDR_W = 32,
    parameter int COLOR_WIDTH   = 16
) (
    input  logic              clk,
    input  logic              rst,
    vga_stream_sink_if.slave  bus
`ifdef VGA_SINK_ERR_COUNT_EN
    ,
    output logic [15:0]       err_count
`endif
);
    localparam int SEL_W = idx_width(CORES_COUNT);
    localparam logic [SEL_W-1:0] LAST_BANK = SEL_W'(CORES_COUNT - 1);

    vga_state_e               state_r, state_next_s;
    logic                     accept_s, restart_s, do_write_s, last_pixel_s;
    logic                     set_done_s, set_err_s, band_wrap_s;
    logic [SEL_W-1:0]         sel_s;
    logic [BUFFER_ADDR_W-1:0] addr_s;

    assign bus.s_ready = !(bus.write && bus.wbusy);
    assign accept_s    = bus.s_valid && bus.s_ready;
    assign restart_s   = accept_s && bus.s_startofpacket;
    assign do_write_s  = accept_s && (bus.s_startofpacket || (state_r == RECV));
    assign last_pixel_s = band_wrap_s && (sel_s == LAST_BANK);

    vga_pixel_addr_gen #(
        .VGA_WIDTH     (VGA_WIDTH),
        .VGA_HEIGHT    (VGA_HEIGHT),
        .CORES_COUNT   (CORES_COUNT),
        .BUFFER_ADDR_W (BUFFER_ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .restart   (restart_s),
        .advance   (do_write_s),
        .sel       (sel_s),
        .addr      (addr_s),
        .band_wrap (band_wrap_s)
    );

    // Framing FSM: next state and pulse requests for the beat accepted this cycle.
    always_comb begin
        state_next_s = state_r;
        set_done_s   = 1'b0;
        set_err_s    = 1'b0;
        if (do_write_s) begin
            if (bus.s_startofpacket && (state_r == RECV)) begin
                set_err_s = 1'b1;
            end else begin
                set_err_s = 1'b0;
            end
            if (last_pixel_s) begin
                if (bus.s_endofpacket) begin
                    set_done_s   = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    set_err_s    = 1'b1;
                    state_next_s = DROP;
                end
            end else if (bus.s_endofpacket) begin
                set_err_s    = 1'b1;
                state_next_s = IDLE;
            end else begin
                state_next_s = RECV;
            end
        end else if (accept_s && (state_r == DROP) && bus.s_endofpacket) begin
            state_next_s = IDLE;
        end else begin
            state_next_s = state_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Write bus and status pulses; the write is held unchanged while the bank stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.write      <= 1'b0;
            bus.wselect    <= {SEL_W{1'b0}};
            bus.waddress   <= {BUFFER_ADDR_W{1'b0}};
            bus.wdata      <= {COLOR_WIDTH{1'b0}};
            bus.frame_done <= 1'b0;
            bus.sync_err   <= 1'b0;
        end else begin
            bus.frame_done <= set_done_s;
            bus.sync_err   <= set_err_s;
            if (do_write_s) begin
                bus.write    <= 1'b1;
                bus.wselect  <= sel_s;
                bus.waddress <= addr_s;
                bus.wdata    <= COLOR_WIDTH'(rgb30_to_565(bus.s_data));
            end else if (bus.write && bus.wbusy) begin
                bus.write <= 1'b1;
            end else begin
                bus.write <= 1'b0;
            end
        end
    end

`ifdef VGA_SINK_ERR_COUNT_EN
    // Saturating framing-error count, updated on the same edge as sync_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= 16'h0000;
        end else if (set_err_s && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'h0001;
        end else begin
            err_count <= err_count;
        end
    end
`endif

endmodule
